prf_multiport: RTL

//   Parametrised physical register file for the out-of-order core, with NUM_WR writeback ports
//   and NUM_RD read ports. Each physical register carries a ready bit (scoreboard).
//   - Rename clears a register's ready bit on allocation; writeback sets it.
//   - Issue/reservation logic reads operand values and readiness.
//   - Same-cycle writeback-to-read bypass on every read port; preg 0 is hardwired zero.

---
 rtl/prf_multiport.sv | 103 ++++++++++
 1 files changed

// File: rtl/prf_multiport.sv
// Physical register file with per-preg ready scoreboard, multiple writeback and read ports,
// same-cycle writeback-to-read bypass, and preg 0 hardwired to zero.
module prf_multiport #(
   parameter int DATA_W    = 32,
   parameter int NUM_PREGS = 64,
   parameter int PREG_W    = $clog2(NUM_PREGS),
   parameter int NUM_RD    = 10,
   parameter int NUM_WR    = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_WR-1:0]              wr_en,
   input  logic [NUM_WR-1:0][PREG_W-1:0]  wr_addr,
   input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data,
   input  logic                           alloc_en,
   input  logic [PREG_W-1:0]              alloc_addr,
   input  logic                           flush,
   input  logic [NUM_RD-1:0][PREG_W-1:0]  rd_addr,
   output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
   output logic [NUM_RD-1:0]              rd_ready,
   output logic [PREG_W:0]                busy_cnt,
   output logic                           wr_conflict
);

   logic [DATA_W-1:0]    mem [NUM_PREGS];
   logic [NUM_PREGS-1:0] ready_q;
   logic [NUM_PREGS-1:0] ready_nxt;
   logic [PREG_W:0]      busy_nxt;
   logic                 conflict_nxt;

   // Ports are walked high to low so the lowest-index port's write lands last and wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREGS; i++) mem[i] <= '0;
      end else begin
         for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en[p] && (wr_addr[p] != '0)) mem[wr_addr[p]] <= wr_data[p];
         end
      end
   end

   // Allocation is applied after writeback so a same-cycle producer leaves the preg busy.
   always_comb begin
      ready_nxt = ready_q;
      if (flush) begin
         ready_nxt = '1;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) ready_nxt[wr_addr[p]] = 1'b1;
         end
         if (alloc_en) ready_nxt[alloc_addr] = 1'b0;
      end
      ready_nxt[0] = 1'b1;
   end

   always_comb begin
      busy_nxt = '0;
      for (int i = 1; i < NUM_PREGS; i++) begin
         if (!ready_nxt[i]) busy_nxt = busy_nxt + (PREG_W+1)'(1);
      end
   end

   always_comb begin
      conflict_nxt = 1'b0;
      for (int a = 0; a < NUM_WR; a++) begin
         for (int b = a + 1; b < NUM_WR; b++) begin
            if (wr_en[a] && wr_en[b] && (wr_addr[a] == wr_addr[b]) && (wr_addr[a] != '0))
               conflict_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ready_q     <= '1;
         busy_cnt    <= '0;
         wr_conflict <= 1'b0;
      end else begin
         ready_q     <= ready_nxt;
         busy_cnt    <= busy_nxt;
         wr_conflict <= conflict_nxt;
      end
   end

   // Same-cycle allocation deliberately does not feed the read path.
   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_data[r]  = mem[rd_addr[r]];
         rd_ready[r] = ready_q[rd_addr[r]];
         for (int p = NUM_WR - 1; p >= 0; p--) begin
            if (wr_en[p] && (wr_addr[p] == rd_addr[r])) begin
               rd_data[r]  = wr_data[p];
               rd_ready[r] = 1'b1;
            end
         end
         if (rd_addr[r] == '0) begin
            rd_data[r]  = '0;
            rd_ready[r] = 1'b1;
         end
      end
   end

endmodule
